mem_access_unit: RTL
====================

# mem_access_unit

Consumer end of the EX/MEM pipeline interface. Takes the registered EX/MEM control and data outputs, resolves branch/jump redirection and drives flush to the earlier stages. Performs load/store transactions on a request/acknowledge data-memory bus, stalling the pipeline until each transaction completes. Delivers load data to the MEM/WB register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ without mem_ack before a bus error; must be ≥1.
- ADDR_W, 32: width of mem_addr.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- Branch_in, MemRead_in, MemWrite_in, Jump_in  in  1 each  MEM control from EX/MEM.
- ALU_zero_in  in  1  branch condition.
- ALU_result_in  in  32  memory address.
- reg_read_data_2_in  in  32  store data.
- branch_addr_in, jump_addr_in  in  32 each  redirect targets.
- pc_redirect  out  1  take new PC this cycle.
- pc_target  out  32  new PC.
- flush_out  out  1  drives IF/ID/EX flush (EX_Flush of EX/MEM).
- stall_out  out  1  freeze PC and all pipeline registers up to EX/MEM.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  transaction complete (one-cycle pulse).
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_read_data  out  32  load result to MEM/WB.
- bus_error  out  1  one-cycle pulse on timeout or misalignment.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: if MemRead_in or MemWrite_in → REQ next edge; latch addr, wdata, we (MemWrite_in wins if both set); clear timeout counter.
- REQ: mem_req=1, mem_addr/mem_wdata/mem_we from latched values. On mem_ack → DONE, latch mem_rdata (reads only; writes leave mem_read_data unchanged). Counter increments each REQ cycle without ack. At count == TIMEOUT_CYCLES-1 with no ack → DONE, mem_read_data=0, bus_error pulsed during the DONE cycle.
- DONE: stall_out=0; pipeline advances on this edge; → IDLE unconditionally, so the same instruction is never re-issued.
- stall_out = (IDLE & (MemRead_in|MemWrite_in)) | REQ.
- Redirect (combinational, gated by !stall_out): Jump_in → pc_target=jump_addr_in; else Branch_in & ALU_zero_in → branch_addr_in. pc_redirect = either condition. flush_out = pc_redirect. Jump has priority.
- mem_ack outside REQ is ignored.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_read_data 0, bus_error 0, counter 0. Combinational outputs follow inputs.
- Minimum load/store: 3 cycles (IDLE stall, REQ with same-cycle ack, DONE); 2 stall cycles.
- A load/store with latency L ack cycles after REQ entry: stall for L+2 cycles.
- mem_read_data is valid in DONE and holds until the next completed read.
- rst during REQ: abort immediately. Next cycle is IDLE with mem_req=0 and stall_out=0 (unless a new access is present). A late mem_ack is ignored.
- Redirect of a branch/jump is never stalled by this block (no access present). pc_redirect is asserted for exactly the cycles the instruction is present.

## Configuration
- MEM_ALIGN_CHECK_EN defined: in IDLE, an access with ALU_result_in[1:0]≠0 goes directly to DONE. No mem_req is issued, mem_read_data=0, and bus_error is pulsed in DONE (1 stall cycle).
- Undefined: no check; address driven unmodified onto the bus.

## Test plan
- Load: MemRead_in=1, ALU_result_in=0x100, mem_ack 2 cycles after REQ with mem_rdata=0xDEADBEEF → mem_addr=0x100, stall 4 cycles, mem_read_data=0xDEADBEEF in DONE.
- Store: MemWrite_in=1, addr 0x20, data 0x12345678, ack same cycle as REQ → mem_we=1, mem_wdata=0x12345678, stall 2 cycles, one mem_req cycle only.
- Timeout with TIMEOUT_CYCLES=4, no ack → 4 REQ cycles, then bus_error=1 for 1 cycle, mem_read_data=0.
- Branch_in=1, ALU_zero_in=1, branch_addr_in=0x40, Jump_in=1, jump_addr_in=0x80 → pc_target=0x80, pc_redirect=flush_out=1. With Jump_in=0, ALU_zero_in=0 → pc_redirect=0.
- rst asserted mid-REQ, then mem_ack 1 cycle later → state IDLE, mem_read_data=0, ack ignored.
- With MEM_ALIGN_CHECK_EN, load at 0x102 → no mem_req, bus_error pulse, 1 stall cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: branch/jump redirect plus a req/ack data-memory transaction FSM.
// Optional MEM_ALIGN_CHECK_EN rejects word-misaligned accesses with a bus error instead of issuing them.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              Jump_in,
  input  logic              ALU_zero_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       reg_read_data_2_in,
  input  logic [31:0]       branch_addr_in,
  input  logic [31:0]       jump_addr_in,
  output logic              pc_redirect,
  output logic [31:0]       pc_target,
  output logic              flush_out,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_read_data,
  output logic              bus_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic             access;
  logic             misalign;
  logic             timeout;

  assign access = MemRead_in | MemWrite_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (ALU_result_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // An ack on the final permitted cycle still completes normally.
  assign timeout = (count == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ack;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (access) state_next = misalign ? DONE : REQ;
      REQ:     if (mem_ack || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_read_data <= '0;
      bus_error     <= 1'b0;
    end else begin
      state     <= state_next;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (access && !misalign) begin
            mem_addr  <= ADDR_W'(ALU_result_in);
            mem_wdata <= reg_read_data_2_in;
            mem_we    <= MemWrite_in;
          end else if (access) begin
            mem_read_data <= '0;
            bus_error     <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) mem_read_data <= mem_rdata;
          end else if (timeout) begin
            mem_read_data <= '0;
            bus_error     <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = (state == REQ);
  assign stall_out = ((state == IDLE) && access) || (state == REQ);

  always_comb begin
    pc_redirect = 1'b0;
    pc_target   = '0;
    if (!stall_out) begin
      if (Jump_in) begin
        pc_redirect = 1'b1;
        pc_target   = jump_addr_in;
      end else if (Branch_in && ALU_zero_in) begin
        pc_redirect = 1'b1;
        pc_target   = branch_addr_in;
      end
    end
  end

  assign flush_out = pc_redirect;

endmodule
